// File: rtl/uart_pkg.sv
// Shared UART definitions used by the register block, the transmit FIFO
// and the serializer: default sizing and the common character type.
package uart_pkg;

   localparam int DEFAULT_DATA_BITS     = 8;
   localparam int DEFAULT_TX_FIFO_DEPTH = 16;

   typedef logic [7:0] uart_char_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART transmit FIFO: one synchronous write port and
// one asynchronous read port. Kept on its own so it can be mapped onto
// distributed RAM later without touching the pointer logic.
module uart_fifo_mem import uart_pkg::*; #(
   parameter int DATA_BITS = DEFAULT_DATA_BITS,
   parameter int DEPTH     = DEFAULT_TX_FIFO_DEPTH,
   localparam int ADDR_W   = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 wr_en_i,
   input  logic [ADDR_W-1:0]    wr_addr_i,
   input  logic [DATA_BITS-1:0] wr_data_i,
   input  logic [ADDR_W-1:0]    rd_addr_i,
   output logic [DATA_BITS-1:0] rd_data_o
);

   logic [DATA_BITS-1:0] mem_q [DEPTH];

   // Write the incoming character; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit byte FIFO between the register block and the serializer.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter; the head character is read show-ahead.
// Optional build macro UART_TX_FIFO_THRESH_EN adds registered
// almost_full / almost_empty flags with AFULL_LEVEL / AEMPTY_LEVEL.
module uart_tx_fifo import uart_pkg::*; #(
   parameter int DATA_BITS    = DEFAULT_DATA_BITS,
   parameter int DEPTH        = DEFAULT_TX_FIFO_DEPTH,
`ifdef UART_TX_FIFO_THRESH_EN
   parameter int AFULL_LEVEL  = DEPTH - 2,
   parameter int AEMPTY_LEVEL = 1,
`endif
   localparam int LEVEL_W     = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic [DATA_BITS-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [DATA_BITS-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LEVEL_W-1:0]   level,
   output logic                 full,
`ifdef UART_TX_FIFO_THRESH_EN
   output logic                 almost_full,
   output logic                 almost_empty,
`endif
   output logic                 empty
);

   localparam int IDX_W = LEVEL_W - 1;

   logic [LEVEL_W-1:0] wr_ptr_q;
   logic [LEVEL_W-1:0] wr_ptr_d;
   logic [LEVEL_W-1:0] rd_ptr_q;
   logic [LEVEL_W-1:0] rd_ptr_d;
   logic               push;
   logic               pop;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                  (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
   assign level = wr_ptr_q - rd_ptr_q;

   // in_ready looks only at our own state, never at out_ready, so a full
   // FIFO cannot pass a character straight through.
   assign in_ready  = !full && !flush && rst;
   assign out_valid = !empty && !flush;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   // Next pointers: flush drops everything held and overrides push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + LEVEL_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + LEVEL_W'(1);
         end
      end
   end

   // Pointer registers; an asserted reset empties the FIFO immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

`ifdef UART_TX_FIFO_THRESH_EN
   logic [LEVEL_W-1:0] level_d;
   logic               almost_full_q;
   logic               almost_empty_q;

   assign level_d = wr_ptr_d - rd_ptr_d;

   // Threshold flags come from the next-state level so they line up with level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         almost_full_q  <= 1'b0;
         almost_empty_q <= 1'b1;
      end else begin
         almost_full_q  <= (level_d >= LEVEL_W'(AFULL_LEVEL));
         almost_empty_q <= (level_d <= LEVEL_W'(AEMPTY_LEVEL));
      end
   end

   assign almost_full  = almost_full_q;
   assign almost_empty = almost_empty_q;
`endif

   uart_fifo_mem #(
      .DATA_BITS (DATA_BITS),
      .DEPTH     (DEPTH)
   ) u_mem (
      .clk       (clk),
      .wr_en_i   (push),
      .wr_addr_i (wr_ptr_q[IDX_W-1:0]),
      .wr_data_i (in_data),
      .rd_addr_i (rd_ptr_q[IDX_W-1:0]),
      .rd_data_o (out_data)
   );

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo. A queue holds the characters the
// FIFO should contain; every falling edge the DUT outputs are compared with
// what that queue implies, and directed phases add literal expectations.
module tb_uart_tx_fifo;
   import uart_pkg::*;

   localparam int DEPTH   = 16;
   localparam int LEVEL_W = $clog2(DEPTH) + 1;

   logic               clk;
   logic               rst;
   logic               flush;
   uart_char_t         in_data;
   logic               in_valid;
   logic               in_ready;
   uart_char_t         out_data;
   logic               out_valid;
   logic               out_ready;
   logic [LEVEL_W-1:0] level;
   logic               full;
   logic               empty;
`ifdef UART_TX_FIFO_THRESH_EN
   logic               almost_full;
   logic               almost_empty;
`endif

   int assertCount = 0;
   int failCount   = 0;

   uart_char_t model[$];

   uart_tx_fifo #(
      .DATA_BITS (8),
      .DEPTH     (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .level        (level),
      .full         (full),
`ifdef UART_TX_FIFO_THRESH_EN
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
`endif
      .empty        (empty)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input uart_char_t d, input logic r, input logic f);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
   endtask

   // Reference contents: a plain queue, cleared by reset or flush, otherwise
   // popped when a character is taken and appended when one is accepted.
   always @(posedge clk or negedge rst) begin
      bit doPush;
      bit doPop;
      if (!rst) begin
         model.delete();
      end else if (flush) begin
         model.delete();
      end else begin
         doPush = in_valid && (model.size() < DEPTH);
         doPop  = out_ready && (model.size() > 0);
         if (doPop) void'(model.pop_front());
         if (doPush) model.push_back(in_data);
      end
   end

   // Every falling edge the DUT outputs must match what the queue implies.
   always @(negedge clk) begin
      int sz;
      sz = model.size();
      checkOutput("level", level, sz);
      checkOutput("empty", empty, sz == 0);
      checkOutput("full", full, sz == DEPTH);
      checkOutput("in_ready", in_ready, rst && !flush && (sz < DEPTH));
      checkOutput("out_valid", out_valid, rst && !flush && (sz > 0));
      if (rst && !flush && sz > 0) checkOutput("out_data", out_data, model[0]);
`ifdef UART_TX_FIFO_THRESH_EN
      checkOutput("almost_full", almost_full, sz >= DEPTH - 2);
      checkOutput("almost_empty", almost_empty, sz <= 1);
`endif
   end

   // Directed phases followed by a randomized soak.
   initial begin
      int readyBias;
      rst       = 1'b0;
      flush     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;

      // Reset then idle.
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_in_ready_held", in_ready, 0);
      checkOutput("rst_level_held", level, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_in_ready_after", in_ready, 1);
      checkOutput("rst_empty_after", empty, 1);
      checkOutput("rst_out_valid_after", out_valid, 0);

      // Fill with the consumer stalled, try a 17th push, then drain.
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, uart_char_t'(8'h41 + i), 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h51, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("fill_full", full, 1);
      checkOutput("fill_level", level, 16);
      checkOutput("fill_in_ready", in_ready, 0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         checkOutput("drain_valid", out_valid, 1);
         checkOutput("drain_data", out_data, 8'h41 + i);
      end
      @(negedge clk);
      checkOutput("drain_empty", empty, 1);

      // Simultaneous push and pop with 4 characters preloaded.
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, uart_char_t'(8'h30 + i), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, uart_char_t'(8'h60 + i), 1'b1, 1'b0);
         @(negedge clk);
         checkOutput("stream_level", level, 4);
         if (i == 0) checkOutput("stream_first_head", out_data, 8'h30);
         if (i == 4) checkOutput("stream_fifth_head", out_data, 8'h60);
      end
      repeat (6) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

      // Backpressure: head must hold steady while the consumer stalls.
      applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("hold_valid", out_valid, 1);
         checkOutput("hold_data", out_data, 8'hA5);
      end
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("hold_pop_empty", empty, 1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

      // Flush with a competing push and pop.
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, uart_char_t'(8'h10 + i), 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h77, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("flush_in_ready", in_ready, 0);
      checkOutput("flush_out_valid", out_valid, 0);
      checkOutput("flush_level_before", level, 7);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("flush_level_after", level, 0);
      checkOutput("flush_empty_after", empty, 1);

      // Randomized soak with drifting consumer speed and rare flushes.
      readyBias = 5;
      for (int i = 0; i < 800; i++) begin
         if (i % 100 == 0) readyBias = $urandom_range(1, 9);
         applyStimulus($urandom_range(0, 9) < 6, uart_char_t'($urandom),
                       $urandom_range(0, 9) < readyBias, $urandom_range(0, 39) == 0);
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

      // Asynchronous reset between edges with 5 characters held.
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, uart_char_t'(8'hC0 + i), 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("arst_level_before", level, 5);
      #2 rst = 1'b0;
      #1;
      checkOutput("arst_level", level, 0);
      checkOutput("arst_out_valid", out_valid, 0);
      checkOutput("arst_empty", empty, 1);
      checkOutput("arst_in_ready", in_ready, 0);
`ifdef UART_TX_FIFO_THRESH_EN
      checkOutput("arst_almost_empty", almost_empty, 1);
      checkOutput("arst_almost_full", almost_full, 0);
`endif
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
